// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
//
// Purpose: groups every hazard-controller signal except clk/reset.
// Modports:
//   master - pipeline side: drives register indices, stage controls,
//            memory handshake and clr_err; receives all controls/status.
//   slave  - hazard controller: the reverse directions.
// Signals:
//   rs1D/rs2D, rs1E/rs2E/rdE, rdM, rdW          register indices (5 bits)
//   ResultSrcE0, RegWriteM, RegWriteW, PCSrcE   stage controls
//   MemReqM, MemReadyM                          data-memory handshake
//   clr_err                                     clears mem_timeout
//   ForwardAE/ForwardBE                         EX operand selects (2 bits)
//   StallF..StallW, FlushD, FlushE              pipeline register en/clr
//   mem_busy, mem_timeout                       memory-wait status
//   stall_cycles, flush_cycles                  performance counters
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             ResultSrcE0, RegWriteM, RegWriteW, PCSrcE;
    logic             MemReqM, MemReadyM, clr_err;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE;
    logic             mem_busy, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE,
        output MemReqM, MemReadyM, clr_err,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  mem_busy, mem_timeout, stall_cycles, flush_cycles
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE,
        input  MemReqM, MemReadyM, clr_err,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output mem_busy, mem_timeout, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller
//
// Purpose: combinational forwarding selects and pipeline hold/clear controls
// (load-use, taken branch, data-memory wait freeze), plus a registered
// memory-wait FSM with sticky timeout flag and stall/flush cycle counters.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high
//   hif   - hazard_ctrl_if slave modport (all pipeline-facing signals)
// Parameters:
//   CNT_W   - performance counter width
//   TIMEOUT - consecutive wait cycles that set mem_timeout (>= 2)
module hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   hif
);
    localparam int              WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0] WC_SET  = WC_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state, state_nxt;
    logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic             lw_stall, mem_stall, timeout_set;
    logic             stall_f, stall_d, stall_e, stall_m, stall_w;
    logic             flush_d, flush_e;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // MEM result beats WB result: it is the younger write to the register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hif.RegWriteM && hif.rdM != 5'd0 && hif.rdM == rs)
            return 2'b10;
        else if (hif.RegWriteW && hif.rdW != 5'd0 && hif.rdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hif.ForwardAE = fwd_sel(hif.rs1E);
    assign hif.ForwardBE = fwd_sel(hif.rs2E);

    assign lw_stall  = hif.ResultSrcE0 && hif.rdE != 5'd0 &&
                       (hif.rdE == hif.rs1D || hif.rdE == hif.rs2D);
    assign mem_stall = hif.MemReqM && !hif.MemReadyM;

    // A memory wait freezes everything and suppresses flushes, so a taken
    // branch sitting in EX keeps PCSrcE high until the freeze lifts.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        stall_w = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            flush_d = hif.PCSrcE;
            flush_e = lw_stall | hif.PCSrcE;
        end
    end

    assign hif.StallF = stall_f;
    assign hif.StallD = stall_d;
    assign hif.StallE = stall_e;
    assign hif.StallM = stall_m;
    assign hif.StallW = stall_w;
    assign hif.FlushD = flush_d;
    assign hif.FlushE = flush_e;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_ONE;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt != WC_MAX)
                        wait_cnt_nxt = wait_cnt + WC_ONE;
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Fires on the edge that moves wait_cnt from TIMEOUT-1 to TIMEOUT.
    assign timeout_set = (state == MEM_WAIT) && mem_stall && (wait_cnt == WC_SET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set)
                timeout_q <= 1'b1;
            else if (hif.clr_err)
                timeout_q <= 1'b0;
            if (stall_f)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_d)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign hif.mem_busy     = (state == MEM_WAIT);
    assign hif.mem_timeout  = timeout_q;
    assign hif.stall_cycles = stall_cnt;
    assign hif.flush_cycles = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    hazard_ctrl_if #(.CNT_W(32)) hif ();

    hazard_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stalls(input string tag, input logic [4:0] exp_fdemw,
                              input logic [1:0] exp_flush_de);
        chk1({tag, "_StallF"}, hif.StallF, exp_fdemw[4]);
        chk1({tag, "_StallD"}, hif.StallD, exp_fdemw[3]);
        chk1({tag, "_StallE"}, hif.StallE, exp_fdemw[2]);
        chk1({tag, "_StallM"}, hif.StallM, exp_fdemw[1]);
        chk1({tag, "_StallW"}, hif.StallW, exp_fdemw[0]);
        chk1({tag, "_FlushD"}, hif.FlushD, exp_flush_de[1]);
        chk1({tag, "_FlushE"}, hif.FlushE, exp_flush_de[0]);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        hif.rs1D = 0; hif.rs2D = 0; hif.rs1E = 0; hif.rs2E = 0;
        hif.rdE = 0; hif.rdM = 0; hif.rdW = 0;
        hif.ResultSrcE0 = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemReadyM = 0; hif.clr_err = 0;
        #1;
        chk1("rst_busy", hif.mem_busy, 1'b0);
        chk1("rst_timeout", hif.mem_timeout, 1'b0);
        chk32("rst_stall_cnt", hif.stall_cycles, 32'd0);
        chk32("rst_flush_cnt", hif.flush_cycles, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Forwarding
        hif.rs1E = 5; hif.rdM = 5; hif.RegWriteM = 1; hif.rdW = 5; hif.RegWriteW = 1;
        #1;
        chk2("fwdA_mem", hif.ForwardAE, 2'b10);
        chk2("fwdB_none", hif.ForwardBE, 2'b00);
        hif.RegWriteM = 0;
        #1;
        chk2("fwdA_wb", hif.ForwardAE, 2'b01);
        hif.rdM = 0; hif.rdW = 0; hif.RegWriteM = 1;
        #1;
        chk2("fwdA_x0", hif.ForwardAE, 2'b00);
        hif.rs2E = 9; hif.rdM = 3; hif.rdW = 9;
        #1;
        chk2("fwdB_wb", hif.ForwardBE, 2'b01);
        hif.rdM = 9;
        #1;
        chk2("fwdB_mem", hif.ForwardBE, 2'b10);
        hif.RegWriteM = 0; hif.RegWriteW = 0;

        // Load-use
        hif.ResultSrcE0 = 1; hif.rdE = 7; hif.rs2D = 7;
        #1;
        chk_stalls("lu", 5'b11000, 2'b01);
        chk32("lu_cnt0", hif.stall_cycles, 32'd0);
        step();
        chk32("lu_cnt1", hif.stall_cycles, 32'd1);
        hif.ResultSrcE0 = 0;
        #1;
        chk1("lu_done", hif.StallF, 1'b0);
        hif.ResultSrcE0 = 1; hif.rdE = 0; hif.rs2D = 0;
        #1;
        chk_stalls("lu_x0", 5'b00000, 2'b00);
        step();
        chk32("lu_x0_cnt", hif.stall_cycles, 32'd1);
        hif.ResultSrcE0 = 0;

        // Branch flush
        hif.PCSrcE = 1;
        #1;
        chk_stalls("br", 5'b00000, 2'b11);
        step();
        chk32("br_flush_cnt", hif.flush_cycles, 32'd1);
        hif.ResultSrcE0 = 1; hif.rdE = 7; hif.rs2D = 7;
        #1;
        chk_stalls("br_lu", 5'b11000, 2'b11);
        step();
        chk32("br_lu_stall_cnt", hif.stall_cycles, 32'd2);
        chk32("br_lu_flush_cnt", hif.flush_cycles, 32'd2);
        hif.ResultSrcE0 = 0; hif.rdE = 0; hif.rs2D = 0;

        // Memory wait with pending branch
        hif.MemReqM = 1; hif.MemReadyM = 0;
        #1;
        chk_stalls("mw_c1", 5'b11111, 2'b00);
        chk1("mw_c1_busy", hif.mem_busy, 1'b0);
        step();
        chk1("mw_c2_busy", hif.mem_busy, 1'b1);
        chk_stalls("mw_c2", 5'b11111, 2'b00);
        step();
        chk1("mw_c3_busy", hif.mem_busy, 1'b1);
        step();
        hif.MemReadyM = 1;
        #1;
        chk1("mw_c4_busy", hif.mem_busy, 1'b1);
        chk_stalls("mw_c4", 5'b00000, 2'b11);
        step();
        chk1("mw_run", hif.mem_busy, 1'b0);
        chk32("mw_stall_cnt", hif.stall_cycles, 32'd5);
        chk32("mw_flush_cnt", hif.flush_cycles, 32'd3);
        hif.MemReqM = 0; hif.MemReadyM = 0; hif.PCSrcE = 0;

        // Timeout: 20-cycle wait
        hif.MemReqM = 1;
        repeat (15) step();
        chk1("to_before", hif.mem_timeout, 1'b0);
        step();
        chk1("to_set", hif.mem_timeout, 1'b1);
        repeat (4) step();
        chk_stalls("to_still_frozen", 5'b11111, 2'b00);
        hif.MemReadyM = 1;
        step();
        chk1("to_sticky", hif.mem_timeout, 1'b1);
        chk1("to_busy_off", hif.mem_busy, 1'b0);
        hif.MemReqM = 0; hif.MemReadyM = 0;
        hif.clr_err = 1;
        step();
        hif.clr_err = 0;
        chk1("to_cleared", hif.mem_timeout, 1'b0);
        chk32("to_stall_cnt", hif.stall_cycles, 32'd25);

        // Set and clear on the same edge: set wins
        hif.MemReqM = 1;
        repeat (15) step();
        hif.clr_err = 1;
        step();
        hif.clr_err = 0;
        chk1("to_set_wins", hif.mem_timeout, 1'b1);
        hif.MemReadyM = 1;
        step();
        hif.MemReqM = 0; hif.MemReadyM = 0;
        chk32("sw_stall_cnt", hif.stall_cycles, 32'd41);

        // Reset mid-wait
        hif.MemReqM = 1;
        repeat (6) step();
        chk1("rmw_busy_pre", hif.mem_busy, 1'b1);
        chk1("rmw_to_pre", hif.mem_timeout, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("rmw_busy", hif.mem_busy, 1'b0);
        chk1("rmw_timeout", hif.mem_timeout, 1'b0);
        chk32("rmw_stall_cnt", hif.stall_cycles, 32'd0);
        chk32("rmw_flush_cnt", hif.flush_cycles, 32'd0);
        chk1("rmw_comb_stall", hif.StallF, 1'b1);
        hif.MemReqM = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
